// File: rtl/number_sprite_reader_if.sv
// Scan-position, ROM and pixel-output signals shared between the sprite reader and its neighbours.
// slave is the reader's view; master is the scan source / ROM / colour-mapper side.
interface number_sprite_reader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              frame_start;
  logic [1:0]        bank_req;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic [9:0]        draw_x;
  logic [9:0]        draw_y;
  logic              pix_valid;
  logic [1:0]        rom_state;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_data;
  logic              pix_out_valid;
  logic              is_number;
  logic [3:0]        color_idx;
  logic [1:0]        bank_active;
  logic [11:0]       last_hit_count;

  modport master (
    output frame_start, bank_req, pos_x, pos_y, draw_x, draw_y, pix_valid, rom_data,
    input  rom_state, rom_addr, pix_out_valid, is_number, color_idx, bank_active,
           last_hit_count
  );

  modport slave (
    input  frame_start, bank_req, pos_x, pos_y, draw_x, draw_y, pix_valid, rom_data,
    output rom_state, rom_addr, pix_out_valid, is_number, color_idx, bank_active,
           last_hit_count
  );
endinterface

// File: rtl/number_sprite_reader.sv
// Read-side controller for the 4-bank number sprite ROM: scan position to ROM address, absorbs the
// ROM's registered read latency and emits aligned pixels with a transparency flag.
module number_sprite_reader #(
  parameter int unsigned SPR_W       = 30,
  parameter int unsigned SPR_H       = 120,
  parameter int unsigned ADDR_W      = 12,
  parameter logic [3:0]  TRANSPARENT = 4'h0
) (
  input logic                    clk,
  input logic                    reset,
  number_sprite_reader_if.slave  bus_io
);

  localparam logic [10:0]       SprW11   = 11'(SPR_W);
  localparam logic [10:0]       SprH11   = 11'(SPR_H);
  localparam logic [ADDR_W-1:0] SprWAddr = ADDR_W'(SPR_W);

  typedef enum logic [0:0] {StWaitFrame, StActive} state_e;

  state_e state_q, state_d;
  logic   accept;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StWaitFrame;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitFrame: if (bus_io.frame_start) state_d = StActive;
      StActive:    state_d = StActive;
      default:     state_d = StWaitFrame;
    endcase
  end

  // FSM: outputs
  always_comb begin
    accept = 1'b0;
    unique case (state_q)
      StWaitFrame: accept = 1'b0;
      StActive:    accept = bus_io.pix_valid;
      default:     accept = 1'b0;
    endcase
  end

  // Stage 0: bounds check in 11 bits so sprites near column/row 1023 cannot wrap into a hit.
  logic [10:0]       x_end, y_end;
  logic [9:0]        rel_x, rel_y;
  logic              hit0;
  logic [ADDR_W-1:0] addr0;

  always_comb begin
    x_end = {1'b0, bus_io.pos_x} + SprW11;
    y_end = {1'b0, bus_io.pos_y} + SprH11;
    hit0  = (bus_io.draw_x >= bus_io.pos_x) && ({1'b0, bus_io.draw_x} < x_end) &&
            (bus_io.draw_y >= bus_io.pos_y) && ({1'b0, bus_io.draw_y} < y_end);
    rel_x = bus_io.draw_x - bus_io.pos_x;
    rel_y = bus_io.draw_y - bus_io.pos_y;
    addr0 = hit0 ? (ADDR_W'(rel_y) * SprWAddr + ADDR_W'(rel_x)) : '0;
  end

  // Stage 1 / stage 2 pipeline registers
  logic [ADDR_W-1:0] rom_addr_q;
  logic [1:0]        rom_state_q;
  logic              valid1_q, hit1_q, valid2_q, hit2_q;
  logic [1:0]        bank_active_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr_q  <= '0;
      rom_state_q <= '0;
      valid1_q    <= 1'b0;
      hit1_q      <= 1'b0;
      valid2_q    <= 1'b0;
      hit2_q      <= 1'b0;
    end else begin
      if (accept) begin
        rom_addr_q  <= addr0;
        rom_state_q <= bank_active_q;
        hit1_q      <= hit0;
      end
      valid1_q <= accept;
      valid2_q <= valid1_q;
      hit2_q   <= hit1_q;
    end
  end

  logic is_number, emit;

  always_comb begin
    is_number = valid2_q && hit2_q && (bus_io.rom_data != TRANSPARENT);
    emit      = is_number;
  end

  // Frame bookkeeping; a pixel emitted alongside frame_start belongs to the new frame.
  logic [11:0] hit_cnt_q, hit_cnt_d, last_hit_q;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (bus_io.frame_start)           hit_cnt_d = emit ? 12'd1 : 12'd0;
    else if (emit && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 12'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q     <= '0;
      last_hit_q    <= '0;
      bank_active_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      if (bus_io.frame_start) begin
        last_hit_q    <= hit_cnt_q;
        bank_active_q <= bus_io.bank_req;
      end
    end
  end

  assign bus_io.rom_addr       = rom_addr_q;
  assign bus_io.rom_state      = rom_state_q;
  assign bus_io.pix_out_valid  = valid2_q;
  assign bus_io.is_number      = is_number;
  assign bus_io.color_idx      = is_number ? bus_io.rom_data : 4'h0;
  assign bus_io.bank_active    = bank_active_q;
  assign bus_io.last_hit_count = last_hit_q;

endmodule
